// File: rtl/ins_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ins_mem_ctrl
// Description : Instruction memory controller. Serves fixed-latency CPU read
//               requests from an internal DEPTH x DWIDTH array and accepts
//               program-load sessions that fill the array from index 0 up.
//               Reads at or beyond the loaded word count return 0 with the
//               out-of-range flag set.
//
// Ports       : clk, rst         - clock, synchronous active-high reset
//               en_ram_in, addr  - one-cycle read request and its address
//               ins, en_ram_out  - returned word and its one-cycle strobe
//               oor              - returned word was out of the loaded range
//               ld_start         - open (or restart) a load session
//               ld_valid/ld_data/ld_last - load word stream
//               ld_ready         - load word accepted this cycle
//               ld_count         - number of words currently loaded
//               busy             - controller is not idle
//               drop             - sticky: a read request was discarded
//
// Revision    : 1.0 - initial release
// ============================================================================
module ins_mem_ctrl #(
    parameter int DWIDTH  = 16,
    parameter int AWIDTH  = 8,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_ram_in,
    input  logic [DWIDTH-1:0] addr,
    output logic [DWIDTH-1:0] ins,
    output logic              en_ram_out,
    output logic              oor,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DWIDTH-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic [AWIDTH:0]   ld_count,
    output logic              busy,
    output logic              drop
);

    localparam int DEPTH = 2**AWIDTH;
    // Width wide enough to hold both a full address and the word count, so
    // the range check compares every address bit.
    localparam int CW    = (DWIDTH > AWIDTH + 1) ? DWIDTH : AWIDTH + 1;

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_load = 2'd1;
    localparam logic [1:0] c_read = 2'd2;
    localparam logic [1:0] c_resp = 2'd3;

    localparam logic [2:0]      c_wait_init = 3'(LATENCY - 1);
    localparam logic [AWIDTH:0] c_last_idx  = (AWIDTH + 1)'(DEPTH - 1);
    localparam logic [AWIDTH:0] c_one       = (AWIDTH + 1)'(1);

    logic [1:0]        r_state;
    logic [1:0]        w_next;
    logic [DWIDTH-1:0] r_addr;
    logic [2:0]        r_wait;
    logic [AWIDTH:0]   r_ld_count;
    logic [DWIDTH-1:0] r_ins;
    logic              r_oor;
    logic              r_drop;
    logic [DWIDTH-1:0] r_mem [DEPTH];

    logic              w_accept;
    logic              w_load_start;
    logic              w_restart;
    logic              w_write;
    logic              w_load_end;
    logic [DWIDTH-1:0] w_rd_addr;
    logic              w_in_range;

    // A read wins over a simultaneous ld_start in IDLE.
    assign w_accept     = (r_state == c_idle) && en_ram_in;
    assign w_load_start = (r_state == c_idle) && !en_ram_in && ld_start;
    // ld_start inside a session restarts it and suppresses that cycle's write.
    assign w_restart    = (r_state == c_load) && ld_start;
    assign w_write      = (r_state == c_load) && !ld_start && ld_valid;
    assign w_load_end   = w_write && (ld_last || (r_ld_count == c_last_idx));

    // With LATENCY=1 the response is formed straight out of IDLE, so the
    // live address is used; otherwise the captured one.
    assign w_rd_addr  = (r_state == c_idle) ? addr : r_addr;
    assign w_in_range = CW'(w_rd_addr) < CW'(r_ld_count);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_idle: begin
                if (en_ram_in) begin
                    w_next = (LATENCY == 1) ? c_resp : c_read;
                end else if (ld_start) begin
                    w_next = c_load;
                end
            end
            c_load: begin
                if (w_load_end) begin
                    w_next = c_idle;
                end
            end
            c_read: begin
                // Counter holds the remaining READ cycles including this one.
                if (r_wait <= 3'd1) begin
                    w_next = c_resp;
                end
            end
            c_resp:  w_next = c_idle;
            default: w_next = c_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        en_ram_out = (r_state == c_resp);
        ld_ready   = (r_state == c_load);
        busy       = (r_state != c_idle);
    end

    assign ins      = r_ins;
    assign oor      = r_oor;
    assign drop     = r_drop;
    assign ld_count = r_ld_count;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= '0;
            r_wait     <= '0;
            r_ld_count <= '0;
            r_ins      <= '0;
            r_oor      <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr <= addr;
                r_wait <= c_wait_init;
            end else if (r_state == c_read) begin
                r_wait <= r_wait - 3'd1;
            end

            if (en_ram_in && (r_state != c_idle)) begin
                r_drop <= 1'b1;
            end

            if (w_load_start || w_restart) begin
                r_ld_count <= '0;
            end else if (w_write) begin
                r_ld_count <= r_ld_count + c_one;
            end

            // Response is registered on entry to RESP and then held until
            // the next response.
            if (w_next == c_resp) begin
                r_ins <= w_in_range ? r_mem[w_rd_addr[AWIDTH-1:0]] : '0;
                r_oor <= !w_in_range;
            end
        end
    end

    // Program storage: write-only from the load path, never cleared.
    always_ff @(posedge clk) begin
        if (w_write && !rst) begin
            r_mem[r_ld_count[AWIDTH-1:0]] <= ld_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ins_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ins_mem_ctrl
// Description : Self-checking bench for ins_mem_ctrl. A behavioural model
//               (word array, loaded count, drop flag) predicts every result.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ins_mem_ctrl;

    localparam int DW  = 16;
    localparam int AW  = 8;
    localparam int LAT = 2;
    localparam int DEP = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en_ram_in = 1'b0;
    logic [DW-1:0] addr = '0;
    logic [DW-1:0] ins;
    logic          en_ram_out;
    logic          oor;
    logic          ld_start = 1'b0;
    logic          ld_valid = 1'b0;
    logic [DW-1:0] ld_data = '0;
    logic          ld_last = 1'b0;
    logic          ld_ready;
    logic [AW:0]   ld_count;
    logic          busy;
    logic          drop;

    ins_mem_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .LATENCY(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .en_ram_in (en_ram_in),
        .addr      (addr),
        .ins       (ins),
        .en_ram_out(en_ram_out),
        .oor       (oor),
        .ld_start  (ld_start),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .ld_ready  (ld_ready),
        .ld_count  (ld_count),
        .busy      (busy),
        .drop      (drop)
    );

    always #5 clk = ~clk;

    // Reference model
    logic [DW-1:0] model_mem [DEP];
    int            model_count = 0;
    logic          model_drop  = 1'b0;
    logic [DW-1:0] last_ins    = '0;
    logic          last_oor    = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ins"},      ins,        0);
        chk({tag, "_strobe"},   en_ram_out, 0);
        chk({tag, "_oor"},      oor,        0);
        chk({tag, "_ld_ready"}, ld_ready,   0);
        chk({tag, "_ld_count"}, ld_count,   0);
        chk({tag, "_busy"},     busy,       0);
        chk({tag, "_drop"},     drop,       0);
        last_ins = '0;
        last_oor = 1'b0;
    endtask

    // Issue one read from IDLE and follow it to its response.
    task automatic do_read(input logic [DW-1:0] a, input bit extra, input bit with_start);
        logic [DW-1:0] e_ins;
        logic          e_oor;
        e_oor = !(int'(a) < model_count);
        e_ins = e_oor ? '0 : model_mem[a[AW-1:0]];
        en_ram_in = 1'b1;
        addr      = a;
        ld_start  = with_start;
        tick;
        en_ram_in = extra;
        ld_start  = 1'b0;
        addr      = ~a;
        if (extra) model_drop = 1'b1;
        for (int i = 1; i < LAT; i++) begin
            chk("rd_wait_strobe", en_ram_out, 0);
            chk("rd_wait_busy",   busy,       1);
            chk("rd_wait_ready",  ld_ready,   0);
            chk("rd_wait_ins_held", ins, last_ins);
            tick;
            en_ram_in = 1'b0;
        end
        chk("rd_strobe", en_ram_out, 1);
        chk("rd_ins",    ins,        e_ins);
        chk("rd_oor",    oor,        e_oor);
        chk("rd_drop",   drop,       model_drop);
        chk("rd_count",  ld_count,   model_count);
        last_ins = e_ins;
        last_oor = e_oor;
        tick;
        chk("rd_after_strobe", en_ram_out, 0);
        chk("rd_after_busy",   busy,       0);
        chk("rd_after_ins",    ins,        last_ins);
        chk("rd_after_oor",    oor,        last_oor);
    endtask

    // Load session of n words; restart_at >= 0 injects one ld_start restart.
    task automatic do_load(input int n, input bit use_last, input int restart_at, input bit fixed);
        int            i;
        int            gaps;
        int            rs;
        logic [DW-1:0] d;
        rs = restart_at;
        gaps = 0;
        ld_start = 1'b1;
        tick;
        ld_start = 1'b0;
        model_count = 0;
        chk("ld_open_ready", ld_ready, 1);
        chk("ld_open_count", ld_count, 0);
        chk("ld_open_busy",  busy,     1);
        i = 0;
        while (i < n) begin
            if (gaps < 40 && $urandom_range(0, 3) == 0) begin
                gaps++;
                ld_valid = 1'b0;
                tick;
                chk("ld_gap_count", ld_count, model_count);
            end else if (i == rs) begin
                rs = -1;
                ld_start = 1'b1;
                ld_valid = 1'b1;
                ld_data  = 16'hDEAD;
                tick;
                ld_start = 1'b0;
                ld_valid = 1'b0;
                model_count = 0;
                i = 0;
                chk("ld_restart_count", ld_count, 0);
                chk("ld_restart_ready", ld_ready, 1);
            end else begin
                d = fixed ? DW'(16'h1001 + i) : DW'($urandom);
                ld_valid = 1'b1;
                ld_data  = d;
                ld_last  = use_last && (i == n - 1);
                tick;
                ld_valid = 1'b0;
                ld_last  = 1'b0;
                model_mem[model_count] = d;
                model_count++;
                i++;
                if (i < n) begin
                    chk("ld_count", ld_count, model_count);
                    chk("ld_ready", ld_ready, 1);
                end
            end
        end
        chk("ld_end_busy",  busy,     0);
        chk("ld_end_ready", ld_ready, 0);
        chk("ld_end_count", ld_count, n);
    endtask

    function automatic logic [DW-1:0] rand_addr();
        logic [DW-1:0] a;
        case ($urandom_range(0, 2))
            0:       a = (model_count > 0) ? DW'($urandom_range(0, model_count - 1)) : '0;
            1:       a = DW'($urandom_range(0, DEP - 1));
            default: a = {8'($urandom_range(1, 255)), 8'($urandom)};
        endcase
        return a;
    endfunction

    initial begin
        // Reset
        tick;
        tick;
        rst = 1'b0;
        chk_reset_vals("reset");

        // Read with nothing loaded
        do_read(16'd3, 0, 0);

        // Known four-word program
        do_load(4, 1, -1, 1);
        do_read(16'd2, 0, 0);
        do_read(16'h0104, 0, 0);
        do_read(16'd3, 0, 0);
        do_read(16'd4, 0, 0);

        // Second request during a read is dropped, drop is sticky
        do_read(16'd1, 1, 0);
        for (int k = 0; k < 10; k++) begin
            tick;
            chk("drop_sticky", drop, 1);
            chk("drop_no_strobe", en_ram_out, 0);
        end

        // Session restart mid-load
        do_load(6, 1, 3, 0);
        for (int k = 0; k < 12; k++) do_read(rand_addr(), 0, 0);

        // Full-depth load without ld_last
        do_load(DEP, 0, -1, 0);
        do_read(16'd5, 0, 1);
        chk("prio_count_kept", ld_count, DEP);
        for (int k = 0; k < 16; k++) do_read(rand_addr(), 0, 0);
        do_read(16'd255, 0, 0);
        do_read(16'd256, 0, 0);

        // Reset one cycle after a read accept
        en_ram_in = 1'b1;
        addr      = 16'd7;
        tick;
        en_ram_in = 1'b0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        model_count = 0;
        model_drop  = 1'b0;
        chk_reset_vals("rst_read");
        for (int k = 0; k < 4; k++) begin
            tick;
            chk("rst_read_no_strobe", en_ram_out, 0);
        end

        // Reset during a load session
        ld_start = 1'b1;
        tick;
        ld_start = 1'b0;
        ld_valid = 1'b1;
        ld_data  = 16'h5555;
        tick;
        tick;
        ld_valid = 1'b0;
        chk("mid_load_count", ld_count, 2);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk_reset_vals("rst_load");
        do_read(16'd0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
